cam_entry_writer: RTL

- Write-side controller for the lookup CAM. Accepts table-programming requests from the control path over a valid/ready handshake and drives the CAM write port (enable, address, data, delete).
- Waits out the CAM's multi-cycle write busy period, then returns a status response.
- Keeps a shadow valid bitmap and an occupancy count, so control logic can see which entries are programmed without a CAM read port.

---
 rtl/cam_wr_pkg.sv | 20 ++
 rtl/cam_entry_writer_if.sv | 27 ++
 rtl/cam_valid_tracker.sv | 49 ++++
 rtl/cam_entry_writer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/cam_wr_pkg.sv
// Shared encodings for the CAM write-side controller: response status codes,
// controller states and the default busy-wait bound.
package cam_wr_pkg;

   localparam logic [1:0] ST_OK       = 2'b00;
   localparam logic [1:0] ST_BAD_ADDR = 2'b01;
   localparam logic [1:0] ST_TIMEOUT  = 2'b10;

   localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

   typedef enum logic [2:0] {
      IDLE,
      HOLD,
      ISSUE,
      ARM,
      WAIT,
      RESP
   } state_e;

endpackage

// File: rtl/cam_entry_writer_if.sv
// Request/response handshake between the control path (master) and the
// CAM entry writer (slave).
interface cam_entry_writer_if #(
   parameter int ADDR_BITS = 4,
   parameter int C_WIDTH   = 205
) ();

   logic                 req_valid;
   logic                 req_ready;
   logic [ADDR_BITS-1:0] req_addr;
   logic [C_WIDTH-1:0]   req_key;
   logic                 req_delete;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [1:0]           resp_status;

   modport master (
      output req_valid, req_addr, req_key, req_delete, resp_ready,
      input  req_ready, resp_valid, resp_status
   );

   modport slave (
      input  req_valid, req_addr, req_key, req_delete, resp_ready,
      output req_ready, resp_valid, resp_status
   );

endinterface

// File: rtl/cam_valid_tracker.sv
// Shadow valid bitmap of the CAM plus a registered population count, so the
// control path can see programmed entries without a CAM read port.
module cam_valid_tracker #(
   parameter int C_DEPTH   = 16,
   parameter int ADDR_BITS = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 set_i,
   input  logic                 clr_i,
   input  logic [ADDR_BITS-1:0] idx_i,
   output logic [C_DEPTH-1:0]   entry_valid_o,
   output logic [ADDR_BITS:0]   entry_count_o
);

   logic [C_DEPTH-1:0] valid_q, valid_d, mask;
   logic [ADDR_BITS:0] count_q, count_d;
   logic               hit;

   // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
   always_comb begin
      mask    = C_DEPTH'(1) << idx_i;
      hit     = |(valid_q & mask);
      valid_d = valid_q;
      count_d = count_q;
      // Count moves only on a real bit transition, which keeps it within 0..C_DEPTH.
      if (set_i && !hit) begin
         valid_d = valid_q | mask;
         count_d = count_q + (ADDR_BITS+1)'(1);
      end else if (clr_i && hit) begin
         valid_d = valid_q & ~mask;
         count_d = count_q - (ADDR_BITS+1)'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid_q <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign entry_valid_o = valid_q;
   assign entry_count_o = count_q;

endmodule

// File: rtl/cam_entry_writer.sv
// Write-side CAM controller: accepts one programming request at a time, drives
// the CAM write port, waits out the CAM busy period and returns a status.
module cam_entry_writer
   import cam_wr_pkg::*;
#(
   parameter int C_DEPTH        = 16,
   parameter int ADDR_BITS      = 4,
   parameter int C_WIDTH        = 205,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                 CLK,
   input  logic                 RST,
   cam_entry_writer_if.slave    req_if,
   output logic                 cam_we,
   output logic [ADDR_BITS-1:0] cam_wr_addr,
   output logic [C_WIDTH-1:0]   cam_din,
   output logic                 cam_delete,
   input  logic                 cam_busy,
   output logic [C_DEPTH-1:0]   entry_valid,
   output logic [ADDR_BITS:0]   entry_count
);

   localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_BITS:0] DEPTH_L  = (ADDR_BITS+1)'(C_DEPTH);

   state_e               state_q;
   logic                 req_ready_q;
   logic                 resp_valid_q;
   logic [1:0]           resp_status_q;
   logic                 cam_we_q;
   logic [ADDR_BITS-1:0] cam_wr_addr_q;
   logic [C_WIDTH-1:0]   cam_din_q;
   logic                 cam_delete_q;
   logic [ADDR_BITS-1:0] addr_q;
   logic [C_WIDTH-1:0]   key_q;
   logic                 del_q;
   logic [CNT_W-1:0]     tmo_cnt_q;
   logic                 upd;

   // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= IDLE;
         req_ready_q   <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_status_q <= ST_OK;
         cam_we_q      <= 1'b0;
         cam_wr_addr_q <= '0;
         cam_din_q     <= '0;
         cam_delete_q  <= 1'b0;
         addr_q        <= '0;
         key_q         <= '0;
         del_q         <= 1'b0;
         tmo_cnt_q     <= '0;
      end else begin
         cam_we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               req_ready_q <= 1'b1;
               if (req_if.req_valid && req_ready_q) begin
                  req_ready_q <= 1'b0;
                  addr_q      <= req_if.req_addr;
                  key_q       <= req_if.req_key;
                  del_q       <= req_if.req_delete;
                  if ({1'b0, req_if.req_addr} >= DEPTH_L) begin
                     state_q       <= RESP;
                     resp_valid_q  <= 1'b1;
                     resp_status_q <= ST_BAD_ADDR;
                  end else begin
                     state_q <= HOLD;
                  end
               end
            end
            // Busy here belongs to earlier CAM activity, so it is waited out without a bound.
            HOLD: begin
               if (!cam_busy) begin
                  state_q       <= ISSUE;
                  cam_we_q      <= 1'b1;
                  cam_wr_addr_q <= addr_q;
                  cam_din_q     <= del_q ? '0 : key_q;
                  cam_delete_q  <= del_q;
               end
            end
            ISSUE: begin
               tmo_cnt_q <= '0;
               state_q   <= ARM;
            end
            // The CAM may raise busy one cycle after the write strobe.
            ARM: state_q <= WAIT;
            WAIT: begin
               tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
               if (!cam_busy) begin
                  state_q       <= RESP;
                  resp_valid_q  <= 1'b1;
                  resp_status_q <= ST_OK;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  state_q       <= RESP;
                  resp_valid_q  <= 1'b1;
                  resp_status_q <= ST_TIMEOUT;
               end
            end
            RESP: begin
               if (req_if.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Bitmap changes on the same edge that moves WAIT to RESP with OK.
   assign upd = (state_q == WAIT) && !cam_busy;

   cam_valid_tracker #(
      .C_DEPTH   (C_DEPTH),
      .ADDR_BITS (ADDR_BITS)
   ) u_tracker (
      .CLK           (CLK),
      .RST           (RST),
      .set_i         (upd && !del_q),
      .clr_i         (upd && del_q),
      .idx_i         (addr_q),
      .entry_valid_o (entry_valid),
      .entry_count_o (entry_count)
   );

   assign req_if.req_ready   = req_ready_q;
   assign req_if.resp_valid  = resp_valid_q;
   assign req_if.resp_status = resp_status_q;
   assign cam_we             = cam_we_q;
   assign cam_wr_addr        = cam_wr_addr_q;
   assign cam_din            = cam_din_q;
   assign cam_delete         = cam_delete_q;

endmodule
